// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
// Shared definitions for the MIPS32 data-memory responder.
//   state_t    : responder FSM encoding (IDLE, WAIT, RESP)
//   WORD_BYTES : bytes per memory word; sets the byte-offset field width
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Word array with a synchronous write port and a combinational read port.
// Both ports share one address. The contents are not reset.
//   clk   in   rising-edge clock
//   we    in   write enable
//   addr  in   word index
//   wdata in   write data
//   rdata out  word at addr (combinational)
module dmem_array #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Multi-cycle data-memory responder at the M-stage load/store interface.
// Accepts one word request at a time, waits LATENCY cycles, performs the
// access and returns a one-cycle response strobe.
//
// Handshake: a request transfers on a rising edge where ReqValid and
// ReqReady are both high. ReqReady is high only in IDLE and depends on the
// state register alone. The response is a single-cycle RespValid strobe with
// no back-pressure; the requester must drop ReqValid on the edge where it
// observes RespValid, otherwise a new request starts when the FSM re-enters IDLE.
//
//   CLK        in   clock, rising edge
//   CLR        in   asynchronous active-low reset
//   ReqValid   in   request present
//   ReqWrite   in   1 = store, 0 = load
//   ReqAddr    in   byte address (wraps modulo the array size)
//   ReqWData   in   store data
//   ReqReady   out  request can be accepted this cycle
//   RespValid  out  one-cycle completion strobe
//   RespRData  out  load data, held until the next response
//   RespErr    out  misaligned address, qualified by RespValid
//   Busy       out  access outstanding (pipeline stall)
//   DbgState   out  current FSM state
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             ReqValid,
    input  logic             ReqWrite,
    input  logic [WIDTH-1:0] ReqAddr,
    input  logic [WIDTH-1:0] ReqWData,
    output logic             ReqReady,
    output logic             RespValid,
    output logic [WIDTH-1:0] RespRData,
    output logic             RespErr,
    output logic             Busy,
    output state_t           DbgState
);

    localparam int CNT_W = 4;
    localparam int OFF_W = $clog2(WORD_BYTES);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             cap_write, cap_write_next;
    logic [WIDTH-1:0] cap_addr, cap_addr_next;
    logic [WIDTH-1:0] cap_wdata, cap_wdata_next;
    logic             resp_valid_next;
    logic             resp_err_next;
    logic [WIDTH-1:0] resp_rdata_next;

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  misaligned;
    logic                  do_access;
    logic                  mem_we;
    logic [WIDTH-1:0]      mem_rdata;
    logic                  unused_addr_hi;

    // Upper address bits are dropped so accesses wrap around the array.
    assign word_idx       = cap_addr[DEPTH_LOG2+OFF_W-1:OFF_W];
    assign misaligned     = |cap_addr[OFF_W-1:0];
    assign unused_addr_hi = ^cap_addr[WIDTH-1:DEPTH_LOG2+OFF_W];

    // A misaligned store must never touch the array.
    assign mem_we   = do_access & cap_write & ~misaligned;
    assign DbgState = state;

    dmem_array #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (CLK),
        .we    (mem_we),
        .addr  (word_idx),
        .wdata (cap_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            RespValid <= 1'b0;
            RespErr   <= 1'b0;
            RespRData <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cap_write <= cap_write_next;
            cap_addr  <= cap_addr_next;
            cap_wdata <= cap_wdata_next;
            RespValid <= resp_valid_next;
            RespErr   <= resp_err_next;
            RespRData <= resp_rdata_next;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        cap_write_next  = cap_write;
        cap_addr_next   = cap_addr;
        cap_wdata_next  = cap_wdata;
        resp_valid_next = 1'b0;
        resp_err_next   = RespErr;
        resp_rdata_next = RespRData;
        do_access       = 1'b0;
        ReqReady        = 1'b0;
        Busy            = 1'b1;

        case (state)
            IDLE: begin
                ReqReady = 1'b1;
                Busy     = 1'b0;
                if (ReqValid) begin
                    cap_write_next = ReqWrite;
                    cap_addr_next  = ReqAddr;
                    cap_wdata_next = ReqWData;
                    cnt_next       = CNT_W'(LATENCY - 1);
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    // Access edge: the strobe and data register together,
                    // so RespValid coincides with the RESP state.
                    do_access       = 1'b1;
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_err_next   = misaligned;
                    if (misaligned) begin
                        resp_rdata_next = '0;
                    end else if (!cap_write) begin
                        resp_rdata_next = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import mips_mem_pkg::*;

    // clock / reset
    logic CLK = 1'b0;
    logic CLR = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // DUT with LATENCY = 2
    logic        ReqValid = 1'b0;
    logic        ReqWrite = 1'b0;
    logic [31:0] ReqAddr  = '0;
    logic [31:0] ReqWData = '0;
    logic        ReqReady, RespValid, RespErr, Busy;
    logic [31:0] RespRData;
    state_t      DbgState;

    // DUT with LATENCY = 1
    logic        v1 = 1'b0;
    logic        w1 = 1'b0;
    logic [31:0] a1 = '0;
    logic [31:0] d1 = '0;
    logic        ReqReady1, RespValid1, RespErr1, Busy1;
    logic [31:0] RespRData1;
    state_t      DbgState1;

    dmem_responder #(.WIDTH(32), .DEPTH_LOG2(6), .LATENCY(2)) dut (
        .CLK(CLK), .CLR(CLR),
        .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .ReqReady(ReqReady), .RespValid(RespValid), .RespRData(RespRData),
        .RespErr(RespErr), .Busy(Busy), .DbgState(DbgState)
    );

    dmem_responder #(.WIDTH(32), .DEPTH_LOG2(6), .LATENCY(1)) dut1 (
        .CLK(CLK), .CLR(CLR),
        .ReqValid(v1), .ReqWrite(w1), .ReqAddr(a1), .ReqWData(d1),
        .ReqReady(ReqReady1), .RespValid(RespValid1), .RespRData(RespRData1),
        .RespErr(RespErr1), .Busy(Busy1), .DbgState(DbgState1)
    );

    // Driver: called #1 after a rising edge with dut in IDLE. Returns the
    // number of edges from acceptance to the sampled RespValid (20 = timeout),
    // and ends #1 after the edge that returns the FSM to IDLE.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
        ReqValid = 1'b1;
        ReqWrite = w;
        ReqAddr  = a;
        ReqWData = d;
        @(posedge CLK); #1;
        ReqValid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge CLK); #1;
            lat++;
            if (RespValid) break;
        end
        rd = RespRData;
        er = RespErr;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        CLR = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        CLR = 1'b1;
        total++;
        if (ReqReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ReqReady); end
        total++;
        if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        total++;
        if (RespValid !== 1'b0) begin bad++; $display("FAIL reset_respvalid got=%b exp=0", RespValid); end
        total++;
        if (RespRData !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", RespRData); end
        total++;
        if (RespErr !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", RespErr); end
        total++;
        if (DbgState !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", DbgState); end
        total++;
        if (ReqReady1 !== 1'b1 || Busy1 !== 1'b0) begin
            bad++; $display("FAIL reset_dut1 ready=%b busy=%b exp ready=1 busy=0", ReqReady1, Busy1);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic er;
        int lat;
        // acceptance edge: dut should be busy in WAIT right after it
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h10; ReqWData = 32'hDEADBEEF;
        @(posedge CLK); #1;
        ReqValid = 1'b0;
        total++;
        if (DbgState !== WAIT || ReqReady !== 1'b0 || Busy !== 1'b1) begin
            bad++; $display("FAIL store_wait state=%0d ready=%b busy=%b exp state=1 ready=0 busy=1",
                            DbgState, ReqReady, Busy);
        end
        lat = 0;
        while (lat < 20) begin
            @(posedge CLK); #1;
            lat++;
            if (RespValid) break;
        end
        total++;
        if (lat !== 2) begin bad++; $display("FAIL store_latency got=%0d exp=2", lat); end
        total++;
        if (RespErr !== 1'b0 || DbgState !== RESP || ReqReady !== 1'b0) begin
            bad++; $display("FAIL store_resp err=%b state=%0d ready=%b exp err=0 state=2 ready=0",
                            RespErr, DbgState, ReqReady);
        end
        @(posedge CLK); #1;
        total++;
        if (RespValid !== 1'b0 || DbgState !== IDLE) begin
            bad++; $display("FAIL store_strobe_len valid=%b state=%0d exp valid=0 state=0", RespValid, DbgState);
        end

        do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
        total++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            bad++; $display("FAIL load_10 lat=%0d data=%h err=%b exp lat=2 data=deadbeef err=0", lat, rd, er);
        end

        // aligned store keeps the previous load data
        do_req(1'b1, 32'h20, 32'hCAFEF00D, rd, er, lat);
        total++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            bad++; $display("FAIL store_holds_rdata lat=%0d data=%h err=%b exp lat=2 data=deadbeef err=0", lat, rd, er);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(1'b1, 32'h100, 32'h12345678, rd, er, lat);
        total++;
        if (lat !== 2 || er !== 1'b0) begin bad++; $display("FAIL wrap_store lat=%0d err=%b exp lat=2 err=0", lat, er); end
        do_req(1'b0, 32'h000, 32'h0, rd, er, lat);
        total++;
        if (rd !== 32'h12345678 || er !== 1'b0) begin
            bad++; $display("FAIL wrap_load data=%h err=%b exp data=12345678 err=0", rd, er);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(1'b1, 32'h22, 32'hFFFFFFFF, rd, er, lat);
        total++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b1) begin
            bad++; $display("FAIL misaligned_store lat=%0d data=%h err=%b exp lat=2 data=0 err=1", lat, rd, er);
        end
        do_req(1'b0, 32'h20, 32'h0, rd, er, lat);
        total++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            bad++; $display("FAIL misaligned_untouched data=%h err=%b exp data=cafef00d err=0", rd, er);
        end
        do_req(1'b0, 32'h13, 32'h0, rd, er, lat);
        total++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            bad++; $display("FAIL misaligned_load data=%h err=%b exp data=0 err=1", rd, er);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        logic er;
        int lat;
        logic seen;
        do_req(1'b1, 32'h08, 32'h11112222, rd, er, lat);
        total++;
        if (lat !== 2 || er !== 1'b0) begin bad++; $display("FAIL pre_store lat=%0d err=%b exp lat=2 err=0", lat, er); end

        seen = 1'b0;
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h08; ReqWData = 32'hA5A5A5A5;
        @(posedge CLK); #1;
        ReqValid = 1'b0;
        total++;
        if (Busy !== 1'b1) begin bad++; $display("FAIL midreset_accept busy=%b exp=1", Busy); end
        @(posedge CLK); #1;
        if (RespValid) seen = 1'b1;
        CLR = 1'b0;
        #1;
        total++;
        if (DbgState !== IDLE || ReqReady !== 1'b1 || Busy !== 1'b0) begin
            bad++; $display("FAIL midreset_async state=%0d ready=%b busy=%b exp state=0 ready=1 busy=0",
                            DbgState, ReqReady, Busy);
        end
        repeat (3) begin
            @(posedge CLK); #1;
            if (RespValid) seen = 1'b1;
        end
        CLR = 1'b1;
        repeat (2) begin
            @(posedge CLK); #1;
            if (RespValid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL midreset_no_resp seen=%b exp=0", seen); end
        do_req(1'b0, 32'h08, 32'h0, rd, er, lat);
        total++;
        if (rd !== 32'h11112222 || er !== 1'b0) begin
            bad++; $display("FAIL midreset_old_value data=%h err=%b exp data=11112222 err=0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        int last_acc;
        int busy_run;
        logic exp_ready, exp_busy, exp_resp;
        state_t exp_state;
        last_acc = -1;
        busy_run = 0;
        @(posedge CLK); #1;
        v1 = 1'b1; w1 = 1'b1; a1 = 32'h4; d1 = 32'h0BADCAFE;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                @(posedge CLK); #1;
            end
            exp_ready = (i % 3 == 0);
            exp_busy  = (i % 3 != 0);
            exp_resp  = (i % 3 == 2);
            exp_state = (i % 3 == 0) ? IDLE : ((i % 3 == 1) ? WAIT : RESP);
            total++;
            if (ReqReady1 !== exp_ready || Busy1 !== exp_busy || RespValid1 !== exp_resp || DbgState1 !== exp_state) begin
                bad++;
                $display("FAIL b2b_cycle%0d ready=%b busy=%b resp=%b state=%0d exp ready=%b busy=%b resp=%b state=%0d",
                         i, ReqReady1, Busy1, RespValid1, DbgState1, exp_ready, exp_busy, exp_resp, exp_state);
            end
            if (ReqReady1) begin
                if (last_acc >= 0) begin
                    total++;
                    if (i - last_acc !== 3) begin bad++; $display("FAIL b2b_spacing got=%0d exp=3", i - last_acc); end
                    total++;
                    if (busy_run !== 2) begin bad++; $display("FAIL b2b_busy_len got=%0d exp=2", busy_run); end
                end
                last_acc = i;
                busy_run = 0;
            end else if (Busy1) begin
                busy_run++;
            end
        end
        // drop the request on the edge that observes RespValid
        v1 = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if (ReqReady1 !== 1'b1 || Busy1 !== 1'b0) begin
            bad++; $display("FAIL b2b_stop ready=%b busy=%b exp ready=1 busy=0", ReqReady1, Busy1);
        end
        total++;
        if (RespErr1 !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b exp=0", RespErr1); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_wrap();
        test_misaligned();
        test_reset_mid_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // absolute time bound in case a wait loop misbehaves
    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
